// File: rtl/fdc_sd_arbiter.sv
// fdc_sd_arbiter
//   Merges the floppy controller's per-drive SD block request channels into a
//   single SD block channel toward the HPS I/O block. Round-robin arbitration
//   keeps exactly one sector transfer in flight; the ack is routed back to the
//   granted drive and that drive's write data is muxed onto sd_buff_din.
//
// Optional feature macro: FDC_ARB_TIMEOUT_EN
//   When defined, a request that sees no sd_ack within TIMEOUT_CYCLES cycles
//   is aborted with a one-cycle err pulse. When undefined, err is tied 0.
//
// Ports
//   CLK, RESET_N      clock, asynchronous active-low reset
//   ch_rd, ch_wr      per-channel read/write request levels
//   ch_lba            per-channel block address, 32 bits per channel
//   ch_buff_din       per-channel write data, 8 bits per channel
//   ch_ack            per-channel ack (combinational, one-hot or zero)
//   sd_rd, sd_wr      merged request toward the SD block interface
//   sd_lba            LBA latched at grant
//   sd_ack            ack from the SD block interface
//   sd_buff_din       write data of the granted channel (combinational)
//   busy              high whenever the arbiter is not idle
//   grant             index of the current/last granted channel
//   err               one-cycle abort pulse (timeout feature only)
module fdc_sd_arbiter #(
  parameter int unsigned NUM_CH         = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NUM_CH-1:0]         ch_rd,
  input  logic [NUM_CH-1:0]         ch_wr,
  input  logic [32*NUM_CH-1:0]      ch_lba,
  input  logic [8*NUM_CH-1:0]       ch_buff_din,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic                      sd_rd,
  output logic                      sd_wr,
  output logic [31:0]               sd_lba,
  input  logic                      sd_ack,
  output logic [7:0]                sd_buff_din,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] grant,
  output logic                      err
);

  localparam int unsigned GW = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   last, last_d, grant_d, sel;
  logic            any_pend;
  logic            sd_rd_d, sd_wr_d, busy_d;
  logic [31:0]     sd_lba_d;
  logic [NUM_CH-1:0] pend;
  logic [31:0]     lba_arr [NUM_CH];
  logic [7:0]      din_arr [NUM_CH];

  assign pend = ch_rd | ch_wr;

  // Unpack the flat per-channel buses
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lba_arr[i] = ch_lba[32*i +: 32];
      din_arr[i] = ch_buff_din[8*i +: 8];
    end
  end

  // Round-robin pick: walk from farthest (last itself) to nearest (last+1);
  // the final hit is the closest pending channel after last.
  always_comb begin
    logic [GW-1:0] idx;
    sel      = last;
    any_pend = 1'b0;
    idx      = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = GW'((int'(last) + i) % NUM_CH);
      if (pend[idx]) begin
        sel      = idx;
        any_pend = 1'b1;
      end
    end
  end

`ifdef FDC_ARB_TIMEOUT_EN
  logic [23:0] to_cnt, to_cnt_d;
  logic        err_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state;
    sd_rd_d  = sd_rd;
    sd_wr_d  = sd_wr;
    sd_lba_d = sd_lba;
    grant_d  = grant;
    last_d   = last;
`ifdef FDC_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt;
    err_d    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (any_pend) begin
          grant_d  = sel;
          last_d   = sel;
          sd_lba_d = lba_arr[sel];
          sd_wr_d  = ch_wr[sel];
          sd_rd_d  = ch_rd[sel] & ~ch_wr[sel];
          state_d  = S_REQ;
`ifdef FDC_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      S_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_XFER;
        end
`ifdef FDC_ARB_TIMEOUT_EN
        else if (to_cnt == TIMEOUT_CYCLES - 24'd1) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          to_cnt_d = to_cnt + 24'd1;
        end
`endif
      end
      S_XFER: begin
        if (!sd_ack) state_d = S_GAP;
      end
      S_GAP: begin
        // One dead cycle so a still-asserted request is re-arbitrated fresh
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      sd_lba <= '0;
      grant  <= '0;
      last   <= GW'(NUM_CH - 1);
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      sd_rd  <= sd_rd_d;
      sd_wr  <= sd_wr_d;
      sd_lba <= sd_lba_d;
      grant  <= grant_d;
      last   <= last_d;
      busy   <= busy_d;
    end
  end

`ifdef FDC_ARB_TIMEOUT_EN
  // Timeout counter and abort pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= to_cnt_d;
      err    <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Ack is forwarded only while a transfer is actually in flight
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i] = sd_ack & ((state == S_REQ) || (state == S_XFER)) & (grant == GW'(i));
    end
  end

  assign sd_buff_din = din_arr[grant];

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Self-checking bench for fdc_sd_arbiter: directed scenarios plus randomized
// request patterns checked against a round-robin reference model.
module tb_fdc_sd_arbiter;

`ifdef FDC_ARB_TIMEOUT_EN
  localparam logic [23:0] TB_TO = 24'd16;
`else
  localparam logic [23:0] TB_TO = 24'd5000000;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic [3:0]   ch_rd, ch_wr, ch_ack;
  logic [127:0] ch_lba;
  logic [31:0]  ch_buff_din;
  logic         sd_rd, sd_wr, sd_ack, busy, err;
  logic [31:0]  sd_lba;
  logic [7:0]   sd_buff_din;
  logic [1:0]   grant;

  fdc_sd_arbiter #(.NUM_CH(4), .TIMEOUT_CYCLES(TB_TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ch_rd(ch_rd), .ch_wr(ch_wr),
    .ch_lba(ch_lba), .ch_buff_din(ch_buff_din), .ch_ack(ch_ack),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .busy(busy), .grant(grant), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: last served channel and per-channel payloads
  int          m_last;
  int          m_sel;
  logic [31:0] lba_v [4];
  logic [7:0]  din_v [4];
  logic        exp_rd, exp_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (pend[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < 4; i++) begin
      ch_lba[32*i +: 32]    = lba_v[i];
      ch_buff_din[8*i +: 8] = din_v[i];
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    ch_rd = '0; ch_wr = '0; sd_ack = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    m_last = 3;
    @(negedge CLK);
  endtask

  // Called just after a negedge with the DUT idle; applies requests and
  // checks the grant that follows one edge later.
  task automatic start_req(input logic [3:0] rd, input logic [3:0] wr);
    ch_rd = rd; ch_wr = wr;
    drive_payload();
    m_sel = rr_pick(rd | wr, m_last);
    @(posedge CLK);
    @(negedge CLK);
    if (m_sel < 0) begin
      check("idle_busy", busy, 0);
      check("idle_rdwr", {sd_rd, sd_wr}, 0);
      return;
    end
    exp_wr = wr[m_sel];
    exp_rd = rd[m_sel] & ~wr[m_sel];
    m_last = m_sel;
    check("grant", grant, m_sel);
    check("sd_lba", sd_lba, lba_v[m_sel]);
    check("sd_wr", sd_wr, exp_wr);
    check("sd_rd", sd_rd, exp_rd);
    check("busy_req", busy, 1);
    check("buff_din", sd_buff_din, din_v[m_sel]);
    check("ack_pre", ch_ack, 0);
  endtask

  // Called just after a negedge with a request outstanding; acks for len cycles.
  task automatic run_ack(input int len);
    logic [3:0] oh;
    oh = 4'b0001 << m_last;
    sd_ack = 1'b1;
    #1 check("ack_rise", ch_ack, oh);
    for (int k = 1; k < len; k++) begin
      @(negedge CLK);
      check("ack_hold", ch_ack, oh);
      check("rdwr_drop", {sd_rd, sd_wr}, 0);
    end
    @(negedge CLK);
    check("rdwr_clr", {sd_rd, sd_wr}, 0);
    sd_ack = 1'b0;
    #1 check("ack_fall", ch_ack, 0);
    @(negedge CLK);
    check("busy_gap", busy, 1);
    check("lba_hold", sd_lba, lba_v[m_last]);
    @(negedge CLK);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin lba_v[i] = '0; din_v[i] = '0; end
    drive_payload();
    do_reset();

    // Reset state
    check("rst_rdwr", {sd_rd, sd_wr}, 0);
    check("rst_lba", sd_lba, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ch_ack, 0);
    check("rst_err", err, 0);

    // Reset in the middle of REQ
    lba_v[0] = 32'h12;
    start_req(4'b0001, 4'b0000);
    RESET_N = 1'b0;
    #1 check("arst_rd", sd_rd, 0);
    check("arst_busy", busy, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    m_last = 3;
    start_req(4'b0001, 4'b0000);
    check("arst_regrant", grant, 0);
    run_ack(3);

    // Single read on channel 2 with a 512-cycle ack
    lba_v[2] = 32'h0000_0123;
    start_req(4'b0100, 4'b0000);
    ch_rd = '0;
    run_ack(512);

    // Round-robin with all channels requesting
    do_reset();
    for (int i = 0; i < 4; i++) lba_v[i] = 32'h1000 + 32'(i);
    for (int t = 0; t < 5; t++) begin
      start_req(4'b1111, 4'b0000);
      check("rr_seq", grant, t % 4);
      run_ack(2);
    end
    ch_rd = '0;

    // Write wins over read and data is muxed from the grant
    for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
    din_v[1] = 8'hA5;
    start_req(4'b0010, 4'b0010);
    check("wr_prio", {sd_wr, sd_rd}, 2'b10);
    check("wr_din", sd_buff_din, 8'hA5);
    ch_rd = '0; ch_wr = '0;
    run_ack(4);

    // Stray ack while idle
    sd_ack = 1'b1;
    #1 check("stray_ack", ch_ack, 0);
    @(negedge CLK);
    check("stray_busy", busy, 0);
    check("stray_ack2", ch_ack, 0);
    sd_ack = 1'b0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rd, wr;
      rd = 4'($urandom);
      wr = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < 4; i++) begin lba_v[i] = $urandom; din_v[i] = 8'($urandom); end
      start_req(rd, wr);
      if (m_sel >= 0) begin
        if ($urandom_range(0, 1) == 1) begin
          ch_rd[m_sel] = 1'b0;
          ch_wr[m_sel] = 1'b0;
        end
        @(negedge CLK);
        check("rnd_hold", {sd_rd, sd_wr}, {exp_rd, exp_wr});
        check("rnd_lba", sd_lba, lba_v[m_sel]);
        run_ack($urandom_range(1, 8));
      end
    end
    ch_rd = '0; ch_wr = '0;

`ifdef FDC_ARB_TIMEOUT_EN
    // Request on channel 3 never acked
    do_reset();
    start_req(4'b1000, 4'b0000);
    for (int k = 1; k < 16; k++) begin
      @(negedge CLK);
      check("to_wait_err", err, 0);
      check("to_wait_rd", sd_rd, 1);
    end
    @(negedge CLK);
    check("to_err", err, 1);
    check("to_rd", sd_rd, 0);
    check("to_ack", ch_ack, 0);
    @(negedge CLK);
    check("to_err_once", err, 0);
    check("to_idle", busy, 0);
    @(negedge CLK);
    check("to_regrant", grant, 3);
    check("to_rd_again", sd_rd, 1);
    ch_rd = '0;
    run_ack(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdc_sd_arbiter.md
Name: fdc_sd_arbiter

Overview:
- Sits directly downstream of the four-drive floppy controller.
- Merges its four per-drive SD block request channels (sd_rd/sd_wr/sd_lba/sd_ack/sd_buff_din per drive) into one single-channel SD block interface toward the HPS I/O block.
- Uses round-robin arbitration, so only one drive's sector transfer is in flight at a time.
- Routes the ack back to the granted drive and muxes that drive's write data to the SD side.

Parameters:
- NUM_CH, 4: number of request channels (drives); grant index width is 2 bits for 4.
- TIMEOUT_CYCLES, 24'd5000000: CLK cycles to wait for sd_ack rise before abort (used only with the optional feature).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ch_rd  in  NUM_CH  per-channel read request (level), from the controller.
- ch_wr  in  NUM_CH  per-channel write request (level).
- ch_lba  in  32 x NUM_CH  per-channel block address.
- ch_buff_din  in  8 x NUM_CH  per-channel write data for the current sd_buff_addr.
- ch_ack  out  NUM_CH  per-channel ack, one-hot or zero.
- sd_rd  out  1  merged read request to the SD block interface.
- sd_wr  out  1  merged write request.
- sd_lba  out  32  latched LBA of the granted request.
- sd_ack  in  1  ack from the SD block interface.
- sd_buff_din  out  8  write data muxed from the granted channel.
- busy  out  1  high whenever the state is not IDLE.
- grant  out  2  index of the current/last granted channel.
- err  out  1  one-cycle abort pulse (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async): state=IDLE. sd_rd=0, sd_wr=0, sd_lba=0, grant=0, ch_ack=0, busy=0, err=0. Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
- A channel is pending when ch_rd[i] | ch_wr[i].
- IDLE:
  - If any channel is pending, select the first pending index searching last+1, last+2, ... modulo NUM_CH.
  - Next edge: grant<=sel, last<=sel, sd_lba<=ch_lba[sel], state<=REQ.
  - In the same edge, sd_wr<=ch_wr[sel] and sd_rd<=ch_rd[sel] & ~ch_wr[sel]. If a channel raises both, write wins.
  - Latency: request visible at edge N gives sd_rd/sd_wr high after edge N.
- REQ:
  - Hold sd_rd/sd_wr and sd_lba stable.
  - When sd_ack=1 is sampled: clear sd_rd/sd_wr at that edge, state<=XFER.
  - A granted channel dropping its request while in REQ does not cancel; the transfer completes.
- XFER: when sd_ack=0 is sampled, state<=GAP.
- GAP: one cycle, then IDLE. This stops a channel that has not yet deasserted its request from being re-granted instantly; a request still pending after GAP is treated as a new request.
- ch_ack (combinational): ch_ack[i] = sd_ack & (state==REQ or XFER) & (grant==i). It is zero in IDLE/GAP, so a stray sd_ack is never forwarded.
- sd_buff_din (combinational) = ch_buff_din[grant] in all states.
- sd_buff_addr, sd_buff_dout and sd_buff_wr are not routed here; they are shared fan-out, and each drive gates them with its own ch_ack.
- Simultaneous requests are served in round-robin order; no channel waits more than NUM_CH-1 transfers.
- sd_lba changes only on grant.
- New requests arriving during REQ/XFER/GAP are held pending, not lost, because requests are levels.

Optional Feature:
- Macro FDC_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYCLES-1 with sd_ack still 0: sd_rd/sd_wr<=0, err pulses high for one cycle, state<=GAP, and no ch_ack is issued.
  - The counter is not active in XFER.
- Undefined: REQ waits indefinitely; err is constant 0.

Test Plan:
- Reset mid-REQ: ch_rd=4'b0001 and lba[0]=32'h12, assert RESET_N=0 while sd_rd=1 → sd_rd=0, busy=0 immediately (asynchronously). After release with ch_rd still high → next grant goes to channel 0.
- Single read, channel 2: ch_rd=4'b0100, ch_lba[2]=32'h0000_0123 → sd_rd=1 and sd_lba=32'h123 one cycle later, grant=2. sd_ack high for 512 cycles → ch_ack=4'b0100 for exactly those cycles, sd_rd drops the cycle after sd_ack rises, busy low 2 cycles after sd_ack falls.
- Round-robin: ch_rd=4'b1111 held after reset, with each transfer acked → grant sequence 0,1,2,3,0. sd_lba tracks ch_lba of each granted channel.
- Write priority and data mux: ch_rd[1]=ch_wr[1]=1, ch_buff_din[1]=8'hA5, others 8'h00 → sd_wr=1, sd_rd=0, sd_buff_din=8'hA5.
- Stray ack: sd_ack pulsed while IDLE → ch_ack stays 4'b0000 and state stays IDLE.
- With FDC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: ch_rd[3]=1, never ack → after 16 cycles in REQ, err pulses once, sd_rd=0. Because ch_rd[3] is still high, the next grant is again channel 3 after GAP.
